// File: rtl/cpu0_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu0_bus_pkg
//  Brief    : Shared types and constants for the CPU/DMA memory bus arbiter
//  Revision : 1.0 - initial release
// ============================================================================
package cpu0_bus_pkg;

  localparam int BUS_W = 32;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // A word access touches addr..addr+3, so the last legal start is MEM_BYTES-4
  function automatic logic addr_in_range(input logic [BUS_W-1:0] addr,
                                         input int mem_bytes);
    return (addr < BUS_W'(mem_bytes - 3));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Brief    : Two-way request picker, round-robin or fixed priority on a tie
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick2
  import cpu0_bus_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic winner_o
);

  // Single requester wins outright; a tie goes to the master not granted last
  // time, or always to master 0 when round-robin is disabled
  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = 1'b0;
    if (req0_i && req1_i) begin
      winner_o = (ROUND_ROBIN != 0) ? ~last_grant_i : 1'b0;
    end else if (req1_i) begin
      winner_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Brief    : Serialises single-word transactions from CPU (m0) and DMA (m1)
//             onto one memory port, with range checking and read capture
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import cpu0_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int MEM_BYTES   = 128,
  parameter int ROUND_ROBIN = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m0_rw,
  input  logic [BUS_W-1:0] m0_addr,
  input  logic [BUS_W-1:0] m0_wdata,
  output logic             m0_ack,
  output logic             m0_err,
  output logic [BUS_W-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_rw,
  input  logic [BUS_W-1:0] m1_addr,
  input  logic [BUS_W-1:0] m1_wdata,
  output logic             m1_ack,
  output logic             m1_err,
  output logic [BUS_W-1:0] m1_rdata,
  output logic             mem_en,
  output logic             mem_rw,
  output logic [BUS_W-1:0] mem_abus,
  output logic [BUS_W-1:0] mem_dbus_in,
  input  logic [BUS_W-1:0] mem_dbus_out,
  output logic             owner,
  output logic             busy
);

  // Counter must hold WAIT_CYCLES; keep at least one bit when it is zero
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e                    state_q;
  logic [CW-1:0]             cnt_q;
  logic                      last_grant_q;
  logic                      owner_q;
  logic                      busy_q;
  logic                      mem_en_q;
  logic                      mem_rw_q;
  logic [BUS_W-1:0]          mem_abus_q;
  logic [BUS_W-1:0]          mem_dbus_in_q;
  logic [1:0]                ack_q;
  logic [1:0]                err_q;
  logic [1:0][BUS_W-1:0]     rdata_q;

  logic                      pick_valid;
  logic                      pick_winner;
  logic                      win_rw;
  logic [BUS_W-1:0]          win_addr;
  logic [BUS_W-1:0]          win_wdata;

  rr_pick2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .req0_i       (m0_req),
    .req1_i       (m1_req),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  // Route the winning master's request fields toward the memory port registers
  always_comb begin
    win_rw    = m0_rw;
    win_addr  = m0_addr;
    win_wdata = m0_wdata;
    if (pick_winner) begin
      win_rw    = m1_rw;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

  // Arbitration FSM and registered datapath; reset drops any in-flight access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      busy_q        <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_rw_q      <= RW_WRITE;
      mem_abus_q    <= '0;
      mem_dbus_in_q <= '0;
      ack_q         <= '0;
      err_q         <= '0;
      rdata_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q       <= pick_winner;
            last_grant_q  <= pick_winner;
            busy_q        <= 1'b1;
            mem_rw_q      <= win_rw;
            mem_abus_q    <= win_addr;
            mem_dbus_in_q <= win_wdata;
            if (addr_in_range(win_addr, MEM_BYTES)) begin
              mem_en_q <= 1'b1;
              cnt_q    <= CW'(WAIT_CYCLES);
              state_q  <= ACCESS;
            end else begin
              ack_q[pick_winner]   <= 1'b1;
              err_q[pick_winner]   <= 1'b1;
              rdata_q[pick_winner] <= '0;
              state_q              <= DONE;
            end
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            if (mem_rw_q == RW_READ) begin
              rdata_q[owner_q] <= mem_dbus_out;
            end
            mem_en_q       <= 1'b0;
            ack_q[owner_q] <= 1'b1;
            err_q[owner_q] <= 1'b0;
            state_q        <= DONE;
          end
        end
        DONE: begin
          ack_q   <= '0;
          err_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m0_ack      = ack_q[0];
  assign m0_err      = err_q[0];
  assign m0_rdata    = rdata_q[0];
  assign m1_ack      = ack_q[1];
  assign m1_err      = err_q[1];
  assign m1_rdata    = rdata_q[1];
  assign mem_en      = mem_en_q;
  assign mem_rw      = mem_rw_q;
  assign mem_abus    = mem_abus_q;
  assign mem_dbus_in = mem_dbus_in_q;
  assign owner       = owner_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Brief    : Directed self-checking bench for mem_bus_arbiter. Three arbiters
//             share one clock/reset: [0] round-robin, no waits; [1] fixed
//             priority, no waits; [2] round-robin, two wait cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  import cpu0_bus_pkg::*;

  localparam int N = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req [N];
  logic        m0_rw [N];
  logic [31:0] m0_addr [N];
  logic [31:0] m0_wdata [N];
  logic        m0_ack [N];
  logic        m0_err [N];
  logic [31:0] m0_rdata [N];
  logic        m1_req [N];
  logic        m1_rw [N];
  logic [31:0] m1_addr [N];
  logic [31:0] m1_wdata [N];
  logic        m1_ack [N];
  logic        m1_err [N];
  logic [31:0] m1_rdata [N];
  logic        mem_en [N];
  logic        mem_rw [N];
  logic [31:0] mem_abus [N];
  logic [31:0] mem_dbus_in [N];
  logic        owner [N];
  logic        busy [N];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  for (genvar k = 0; k < N; k++) begin : g_dut
    logic [7:0]  mem [128];
    logic [6:0]  a;
    logic [31:0] dbus_out;

    assign a = mem_abus[k][6:0];
    // Big-endian byte memory; garbage on the bus while disabled
    assign dbus_out = mem_en[k] ? {mem[a], mem[a + 7'd1], mem[a + 7'd2], mem[a + 7'd3]}
                                : 32'hDEAD_BEEF;

    initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      {mem[0], mem[1], mem[2], mem[3]} = 32'h001F_0018;
      {mem[4], mem[5], mem[6], mem[7]} = 32'h002F_0010;
    end

    always @(posedge clock) begin
      if (mem_en[k] && mem_rw[k] == RW_WRITE) begin
        mem[a]        <= mem_dbus_in[k][31:24];
        mem[a + 7'd1] <= mem_dbus_in[k][23:16];
        mem[a + 7'd2] <= mem_dbus_in[k][15:8];
        mem[a + 7'd3] <= mem_dbus_in[k][7:0];
      end
    end

    mem_bus_arbiter #(
      .WAIT_CYCLES (k == 2 ? 2 : 0),
      .MEM_BYTES   (128),
      .ROUND_ROBIN (k == 1 ? 0 : 1)
    ) u_dut (
      .clock        (clock),
      .reset        (reset),
      .m0_req       (m0_req[k]),
      .m0_rw        (m0_rw[k]),
      .m0_addr      (m0_addr[k]),
      .m0_wdata     (m0_wdata[k]),
      .m0_ack       (m0_ack[k]),
      .m0_err       (m0_err[k]),
      .m0_rdata     (m0_rdata[k]),
      .m1_req       (m1_req[k]),
      .m1_rw        (m1_rw[k]),
      .m1_addr      (m1_addr[k]),
      .m1_wdata     (m1_wdata[k]),
      .m1_ack       (m1_ack[k]),
      .m1_err       (m1_err[k]),
      .m1_rdata     (m1_rdata[k]),
      .mem_en       (mem_en[k]),
      .mem_rw       (mem_rw[k]),
      .mem_abus     (mem_abus[k]),
      .mem_dbus_in  (mem_dbus_in[k]),
      .mem_dbus_out (dbus_out),
      .owner        (owner[k]),
      .busy         (busy[k])
    );
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_master(input int k, input bit m, input logic req, input logic rw,
                            input logic [31:0] addr, input logic [31:0] wdata);
    if (m) begin
      m1_req[k] = req; m1_rw[k] = rw; m1_addr[k] = addr; m1_wdata[k] = wdata;
    end else begin
      m0_req[k] = req; m0_rw[k] = rw; m0_addr[k] = addr; m0_wdata[k] = wdata;
    end
  endtask

  // One transaction from master m of arbiter k; edges=99 when no ack arrives
  task automatic run_txn(input int k, input bit m, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata, output int edges, output int en_cycles,
                         output int other_acks, output logic err, output logic [31:0] rdata);
    logic got;
    set_master(k, m, 1'b1, rw, addr, wdata);
    edges = 0; en_cycles = 0; other_acks = 0; got = 1'b0;
    while (!got && edges < 20) begin
      tick();
      edges++;
      if (mem_en[k]) en_cycles++;
      if (m ? m0_ack[k] : m1_ack[k]) other_acks++;
      got = m ? m1_ack[k] : m0_ack[k];
    end
    err   = m ? m1_err[k] : m0_err[k];
    rdata = m ? m1_rdata[k] : m0_rdata[k];
    if (!got) edges = 99;
    set_master(k, m, 1'b0, rw, addr, wdata);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      set_master(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_master(k, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    tick(); tick();
    for (int k = 0; k < N; k += 2) begin
      tests_run++;
      if ({mem_en[k], mem_rw[k], owner[k], busy[k], m0_ack[k], m1_ack[k], m0_err[k], m1_err[k]} !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 00000000", k,
                 {mem_en[k], mem_rw[k], owner[k], busy[k], m0_ack[k], m1_ack[k], m0_err[k], m1_err[k]});
      end
      tests_run++;
      if ({mem_abus[k], mem_dbus_in[k], m0_rdata[k], m1_rdata[k]} !== 128'h0) begin
        tests_failed++;
        $display("FAIL reset_data[%0d]: got %h expected 0", k,
                 {mem_abus[k], mem_dbus_in[k], m0_rdata[k], m1_rdata[k]});
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_read();
    int m1_seen;
    m1_seen = 0;
    set_master(0, 1'b0, 1'b1, RW_READ, 32'h0, 32'h0);
    tick();
    if (m1_ack[0]) m1_seen++;
    tests_run++;
    if ({mem_en[0], busy[0], owner[0], m0_ack[0]} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL read_access: got en/busy/owner/ack=%b expected 1100",
               {mem_en[0], busy[0], owner[0], m0_ack[0]});
    end
    tick();
    if (m1_ack[0]) m1_seen++;
    tests_run++;
    if ({m0_ack[0], m0_err[0], mem_en[0]} !== 3'b100) begin
      tests_failed++;
      $display("FAIL read_ack: got ack/err/en=%b expected 100", {m0_ack[0], m0_err[0], mem_en[0]});
    end
    tests_run++;
    if (m0_rdata[0] !== 32'h001F_0018) begin
      tests_failed++;
      $display("FAIL read_data: got %h expected 001f0018", m0_rdata[0]);
    end
    set_master(0, 1'b0, 1'b0, RW_READ, 32'h0, 32'h0);
    tick();
    if (m1_ack[0]) m1_seen++;
    tests_run++;
    if ({m0_ack[0], busy[0], m1_seen != 0} !== 3'b000) begin
      tests_failed++;
      $display("FAIL read_done: got ack/busy/m1ack=%b expected 000", {m0_ack[0], busy[0], m1_seen != 0});
    end
  endtask

  task automatic test_write_read();
    int e, en, oth; logic err; logic [31:0] rd;
    run_txn(0, 1'b1, RW_WRITE, 32'h20, 32'h1234_5678, e, en, oth, err, rd);
    tests_run++;
    if (e !== 2 || err !== 1'b0 || en !== 1) begin
      tests_failed++;
      $display("FAIL write_ack: got edges=%0d err=%b en=%0d expected 2 0 1", e, err, en);
    end
    tests_run++;
    if ({g_dut[0].mem[32], g_dut[0].mem[35]} !== 16'h1278) begin
      tests_failed++;
      $display("FAIL write_bytes: got %h expected 1278", {g_dut[0].mem[32], g_dut[0].mem[35]});
    end
    run_txn(0, 1'b0, RW_READ, 32'h20, 32'h0, e, en, oth, err, rd);
    tests_run++;
    if (rd !== 32'h1234_5678 || e !== 2) begin
      tests_failed++;
      $display("FAIL readback: got %h edges=%0d expected 12345678 edges=2", rd, e);
    end
  endtask

  task automatic test_arbitration(input int k, input logic [7:0] exp_order);
    int n0, n1, nack, cyc, last_cyc, bad_gap, both;
    logic [7:0] order;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_master(k, 1'b0, 1'b1, RW_READ, 32'h0, 32'h0);
    set_master(k, 1'b1, 1'b1, RW_READ, 32'h4, 32'h0);
    n0 = 0; n1 = 0; nack = 0; cyc = 0; last_cyc = 0; bad_gap = 0; both = 0; order = '0;
    while ((n0 < 4 || n1 < 4) && cyc < 100) begin
      tick();
      cyc++;
      if (m0_ack[k] && m1_ack[k]) both++;
      if (m0_ack[k] || m1_ack[k]) begin
        if (nack == 0) begin
          if (cyc != 2) bad_gap++;
        end else if (cyc - last_cyc != 3) begin
          bad_gap++;
        end
        if (nack < 8) order[nack] = m1_ack[k];
        nack++;
        last_cyc = cyc;
        if (m0_ack[k]) begin n0++; if (n0 == 4) m0_req[k] = 1'b0; end
        if (m1_ack[k]) begin n1++; if (n1 == 4) m1_req[k] = 1'b0; end
      end
    end
    tick();
    tests_run++;
    if (nack !== 8 || order !== exp_order) begin
      tests_failed++;
      $display("FAIL arb_order[%0d]: got acks=%0d order=%b expected 8 %b", k, nack, order, exp_order);
    end
    tests_run++;
    if (bad_gap !== 0 || both !== 0) begin
      tests_failed++;
      $display("FAIL arb_spacing[%0d]: got bad_gaps=%0d dual_acks=%0d expected 0 0", k, bad_gap, both);
    end
    tests_run++;
    if ({m0_rdata[k], m1_rdata[k]} !== 64'h001F_0018_002F_0010) begin
      tests_failed++;
      $display("FAIL arb_data[%0d]: got %h %h expected 001f0018 002f0010", k, m0_rdata[k], m1_rdata[k]);
    end
  endtask

  task automatic test_out_of_range();
    int e, en, oth; logic err; logic [31:0] rd;
    run_txn(0, 1'b0, RW_READ, 32'd125, 32'h0, e, en, oth, err, rd);
    tests_run++;
    if (e !== 1 || err !== 1'b1 || rd !== 32'h0 || en !== 0) begin
      tests_failed++;
      $display("FAIL oor_125: got edges=%0d err=%b rdata=%h en=%0d expected 1 1 0 0", e, err, rd, en);
    end
    run_txn(0, 1'b0, RW_READ, 32'd124, 32'h0, e, en, oth, err, rd);
    tests_run++;
    if (e !== 2 || err !== 1'b0 || en !== 1) begin
      tests_failed++;
      $display("FAIL oor_124: got edges=%0d err=%b en=%0d expected 2 0 1", e, err, en);
    end
  endtask

  task automatic test_wait_states();
    int e, en, oth; logic err; logic [31:0] rd;
    run_txn(2, 1'b1, RW_READ, 32'h4, 32'h0, e, en, oth, err, rd);
    tests_run++;
    if (e !== 4 || en !== 3 || oth !== 0) begin
      tests_failed++;
      $display("FAIL wait_timing: got edges=%0d en=%0d m0acks=%0d expected 4 3 0", e, en, oth);
    end
    tests_run++;
    if (rd !== 32'h002F_0010 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_data: got %h err=%b expected 002f0010 0", rd, err);
    end
  endtask

  task automatic test_async_reset();
    int e; logic got;
    set_master(0, 1'b1, 1'b1, RW_READ, 32'h4, 32'h0);
    tick();
    tests_run++;
    if ({mem_en[0], owner[0], busy[0]} !== 3'b111) begin
      tests_failed++;
      $display("FAIL ar_pre: got en/owner/busy=%b expected 111", {mem_en[0], owner[0], busy[0]});
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({mem_en[0], owner[0], busy[0], m1_ack[0], m1_rdata[0]} !== 36'h0) begin
      tests_failed++;
      $display("FAIL ar_immediate: got en/owner/busy/ack=%b rdata=%h expected 0000 0",
               {mem_en[0], owner[0], busy[0], m1_ack[0]}, m1_rdata[0]);
    end
    @(posedge clock);
    #1;
    tests_run++;
    if (m1_ack[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL ar_no_ack: got %b expected 0", m1_ack[0]);
    end
    @(negedge clock);
    reset = 1'b0;
    e = 0; got = 1'b0;
    while (!got && e < 20) begin
      tick();
      e++;
      got = m1_ack[0];
    end
    tests_run++;
    if (e !== 2 || m1_rdata[0] !== 32'h002F_0010) begin
      tests_failed++;
      $display("FAIL ar_reissue: got edges=%0d rdata=%h expected 2 002f0010", e, m1_rdata[0]);
    end
    set_master(0, 1'b0, 1'b1, RW_READ, 32'h0, 32'h0);
    tick();
    tick();
    tests_run++;
    if ({owner[0], busy[0]} !== 2'b01) begin
      tests_failed++;
      $display("FAIL ar_tie: got owner/busy=%b expected 01", {owner[0], busy[0]});
    end
    e = 0; got = 1'b0;
    while (!got && e < 20) begin
      tick();
      e++;
      got = m0_ack[0];
    end
    tests_run++;
    if (got !== 1'b1 || m1_ack[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL ar_m0_ack: got m0ack=%b m1ack=%b expected 1 0", got, m1_ack[0]);
    end
    m0_req[0] = 1'b0;
    m1_req[0] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_arbitration(0, 8'hAA);
    test_arbitration(1, 8'hF0);
    test_out_of_range();
    test_wait_states();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
`default_nettype wire
